// File: rtl/mycpu_mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: holds the MEM pipeline register,
// issues loads/stores to the data SRAM and holds returned load data for WB.
module mycpu_mem_stage #(
    parameter int unsigned DEST_W = 5
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [31:0]       es_alu_result,
    input  logic [31:0]       es_rt_cont,
    input  logic [5:0]        es_mode,
    input  logic [2:0]        es_st_op,
    input  logic              es_gr_we,
    input  logic [DEST_W-1:0] es_dest,

    output logic              ms_to_ws_valid,
    input  logic              ws_allowin,
    output logic [31:0]       ms_alu_result,
    output logic [31:0]       ms_rt_cont,
    output logic [5:0]        ms_mode,
    output logic              ms_gr_we,
    output logic [DEST_W-1:0] ms_dest,
    output logic              ms_addr_err,

    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [31:0]       data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    input  logic [31:0]       data_sram_rdata,

    output logic [31:0]       ms_ld_rdata
);

    typedef enum logic [2:0] {
        ST_NONE = 3'b000,
        ST_SB   = 3'b001,
        ST_SH   = 3'b010,
        ST_SW   = 3'b011,
        ST_SWL  = 3'b100,
        ST_SWR  = 3'b101
    } st_op_e;

    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_LWL = 3'b011,
        SZ_LWR = 3'b100
    } ld_size_e;

    logic              ms_valid_q, ms_valid_d;
    logic [31:0]       alu_result_q;
    logic [31:0]       rt_cont_q;
    logic [5:0]        mode_q;
    st_op_e            st_op_q;
    logic              gr_we_q;
    logic [DEST_W-1:0] dest_q;

    logic              rd_pending_q, rd_pending_d;
    logic              ld_buf_vld_q, ld_buf_vld_d;
    logic [31:0]       ld_buf_q, ld_buf_d;

    logic              payload_ld;
    logic [1:0]        a;
    logic              is_load;
    logic              is_store;
    ld_size_e          ld_sz;
    logic              err_ld;
    logic              err_st;
    logic [3:0]        st_wen;
    logic [31:0]       st_wdata;

    assign ms_allowin     = !ms_valid_q || ws_allowin;
    assign ms_to_ws_valid = ms_valid_q;
    assign payload_ld     = es_to_ms_valid && ms_allowin;

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
    end

    assign a        = alu_result_q[1:0];
    assign is_load  = mode_q[5];
    assign is_store = (st_op_q != ST_NONE);
    assign ld_sz    = ld_size_e'(mode_q[3:1]);

    // Byte accesses and the unaligned lwl/lwr/swl/swr forms can never fault.
    always_comb begin
        err_ld = 1'b0;
        if (is_load) begin
            case (ld_sz)
                SZ_H:    err_ld = a[0];
                SZ_W:    err_ld = |a;
                default: err_ld = 1'b0;
            endcase
        end
    end

    always_comb begin
        err_st = 1'b0;
        case (st_op_q)
            ST_SH:   err_st = a[0];
            ST_SW:   err_st = |a;
            default: err_st = 1'b0;
        endcase
    end

    assign ms_addr_err = err_ld || err_st;

    // Issue only as the instruction leaves for WB, so a WB stall never repeats a store.
    assign data_sram_en   = ms_valid_q && ws_allowin && (is_load || is_store) && !ms_addr_err;
    assign data_sram_addr = {alu_result_q[31:2], 2'b00};

    always_comb begin
        st_wen   = '0;
        st_wdata = '0;
        case (st_op_q)
            ST_SB: begin
                st_wen   = 4'b0001 << a;
                st_wdata = {4{rt_cont_q[7:0]}};
            end
            ST_SH: begin
                st_wen   = a[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rt_cont_q[15:0]}};
            end
            ST_SW: begin
                st_wen   = 4'b1111;
                st_wdata = rt_cont_q;
            end
            ST_SWL: begin
                case (a)
                    2'd0: begin st_wen = 4'b0001; st_wdata = {24'b0, rt_cont_q[31:24]}; end
                    2'd1: begin st_wen = 4'b0011; st_wdata = {16'b0, rt_cont_q[31:16]}; end
                    2'd2: begin st_wen = 4'b0111; st_wdata = {8'b0, rt_cont_q[31:8]}; end
                    default: begin st_wen = 4'b1111; st_wdata = rt_cont_q; end
                endcase
            end
            ST_SWR: begin
                case (a)
                    2'd0: begin st_wen = 4'b1111; st_wdata = rt_cont_q; end
                    2'd1: begin st_wen = 4'b1110; st_wdata = {rt_cont_q[23:0], 8'b0}; end
                    2'd2: begin st_wen = 4'b1100; st_wdata = {rt_cont_q[15:0], 16'b0}; end
                    default: begin st_wen = 4'b1000; st_wdata = {rt_cont_q[7:0], 24'b0}; end
                endcase
            end
            default: begin
                st_wen   = '0;
                st_wdata = '0;
            end
        endcase
    end

    assign data_sram_wen   = (data_sram_en && is_store) ? st_wen : '0;
    assign data_sram_wdata = st_wdata;

    // Read data is only valid the cycle after issue; keep a copy while WB stalls.
    always_comb begin
        rd_pending_d = data_sram_en && is_load;
        ld_buf_d     = ld_buf_q;
        ld_buf_vld_d = ld_buf_vld_q;
        if (rd_pending_q) begin
            ld_buf_d     = data_sram_rdata;
            ld_buf_vld_d = 1'b1;
        end
        if (data_sram_en) begin
            ld_buf_vld_d = 1'b0;
        end
    end

    assign ms_ld_rdata = ld_buf_vld_q ? ld_buf_q : data_sram_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            alu_result_q <= '0;
            rt_cont_q    <= '0;
            mode_q       <= '0;
            st_op_q      <= ST_NONE;
            gr_we_q      <= 1'b0;
            dest_q       <= '0;
            rd_pending_q <= 1'b0;
            ld_buf_vld_q <= 1'b0;
            ld_buf_q     <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            rd_pending_q <= rd_pending_d;
            ld_buf_vld_q <= ld_buf_vld_d;
            ld_buf_q     <= ld_buf_d;
            if (payload_ld) begin
                alu_result_q <= es_alu_result;
                rt_cont_q    <= es_rt_cont;
                mode_q       <= es_mode;
                st_op_q      <= st_op_e'(es_st_op);
                gr_we_q      <= es_gr_we;
                dest_q       <= es_dest;
            end
        end
    end

    assign ms_alu_result = alu_result_q;
    assign ms_rt_cont    = rt_cont_q;
    assign ms_mode       = mode_q;
    assign ms_gr_we      = gr_we_q;
    assign ms_dest       = dest_q;

endmodule

// File: tb/tb_mycpu_mem_stage.sv
// Bench for mycpu_mem_stage: directed scenarios plus random traffic, checked
// against a transaction-level model with a behavioural data SRAM.
module tb_mycpu_mem_stage;

    localparam int DW = 5;
    localparam logic [5:0] LW = 6'b100100;

    logic          clk = 1'b0;
    logic          resetn;
    logic          es_to_ms_valid;
    logic          ms_allowin;
    logic [31:0]   es_alu_result;
    logic [31:0]   es_rt_cont;
    logic [5:0]    es_mode;
    logic [2:0]    es_st_op;
    logic          es_gr_we;
    logic [DW-1:0] es_dest;
    logic          ms_to_ws_valid;
    logic          ws_allowin;
    logic [31:0]   ms_alu_result;
    logic [31:0]   ms_rt_cont;
    logic [5:0]    ms_mode;
    logic          ms_gr_we;
    logic [DW-1:0] ms_dest;
    logic          ms_addr_err;
    logic          data_sram_en;
    logic [3:0]    data_sram_wen;
    logic [31:0]   data_sram_addr;
    logic [31:0]   data_sram_wdata;
    logic [31:0]   data_sram_rdata;
    logic [31:0]   ms_ld_rdata;

    mycpu_mem_stage #(.DEST_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_alu_result(es_alu_result), .es_rt_cont(es_rt_cont),
        .es_mode(es_mode), .es_st_op(es_st_op), .es_gr_we(es_gr_we), .es_dest(es_dest),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_alu_result(ms_alu_result), .ms_rt_cont(ms_rt_cont), .ms_mode(ms_mode),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_addr_err(ms_addr_err),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .ms_ld_rdata(ms_ld_rdata)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    logic [31:0] mem [16];
    bit          idle_zero;

    // model: instruction sitting in MEM, and the load sitting in WB
    logic          mv;
    logic [31:0]   p_alu, p_rt;
    logic [5:0]    p_mode;
    logic [2:0]    p_st;
    logic          p_we;
    logic [DW-1:0] p_dest;
    logic          wb_load;
    logic [31:0]   wb_exp;
    logic          m_allowin, m_err, m_en;
    logic [3:0]    m_wen;
    logic [31:0]   m_wdata;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] alu;
        logic [3:0]  wen;
        logic [31:0] wd;
    } st_vec_t;
    st_vec_t svec [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mv = 1'b0; p_alu = '0; p_rt = '0; p_mode = '0; p_st = '0; p_we = 1'b0; p_dest = '0;
        wb_load = 1'b0; wb_exp = '0;
    endfunction

    // Outputs follow from the access size and address using plain arithmetic.
    function automatic void model_outputs();
        int  a    = int'(p_alu[1:0]);
        int  need = 1;
        bit  ld   = p_mode[5];
        bit  st   = (p_st != 3'd0);
        if (ld) begin
            if (p_mode[3:1] == 3'd1) need = 2;
            else if (p_mode[3:1] == 3'd2) need = 4;
        end
        if (p_st == 3'd2) need = 2;
        if (p_st == 3'd3) need = 4;
        m_err     = (a % need) != 0;
        m_allowin = !mv || ws_allowin;
        m_en      = mv && ws_allowin && (ld || st) && !m_err;
        m_wen     = '0;
        m_wdata   = '0;
        case (p_st)
            3'd1: begin m_wen = 4'b0001 << a; m_wdata = 32'(p_rt[7:0]) * 32'h01010101; end
            3'd2: begin m_wen = 4'b0011 << (a & 2); m_wdata = 32'(p_rt[15:0]) * 32'h00010001; end
            3'd3: begin m_wen = 4'hF; m_wdata = p_rt; end
            3'd4: begin m_wen = 4'((1 << (a + 1)) - 1); m_wdata = p_rt >> (8 * (3 - a)); end
            3'd5: begin m_wen = 4'hF << a; m_wdata = p_rt << (8 * a); end
            default: ;
        endcase
        if (!(m_en && st)) m_wen = '0;
    endfunction

    task automatic model_edge(output logic [31:0] rd);
        int idx = int'(p_alu[5:2]);
        logic [31:0] word = mem[idx];
        if (m_en && p_st != 3'd0) begin
            for (int b = 0; b < 4; b++)
                if (m_wen[b]) mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
        end
        if (m_en && p_mode[5]) rd = word;
        else rd = idle_zero ? 32'h0 : $urandom;
        if (ws_allowin) begin
            wb_load = m_en && p_mode[5];
            wb_exp  = word;
        end
        if (m_allowin) begin
            mv = es_to_ms_valid;
            if (es_to_ms_valid) begin
                p_alu = es_alu_result; p_rt = es_rt_cont; p_mode = es_mode;
                p_st = es_st_op; p_we = es_gr_we; p_dest = es_dest;
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                        input logic [5:0] mode, input logic [2:0] st, input logic ws);
        logic [31:0] rd;
        @(posedge clk);
        model_edge(rd);
        #1;
        data_sram_rdata = rd;
        es_to_ms_valid  = v;
        es_alu_result   = alu;
        es_rt_cont      = rt;
        es_mode         = mode;
        es_st_op        = st;
        es_gr_we        = 1'($urandom);
        es_dest         = DW'($urandom);
        ws_allowin      = ws;
        model_outputs();
        @(negedge clk);
        chk("ms_to_ws_valid", 32'(ms_to_ws_valid), 32'(mv));
        chk("ms_allowin", 32'(ms_allowin), 32'(m_allowin));
        chk("ms_addr_err", 32'(ms_addr_err), 32'(m_err));
        chk("sram_en", 32'(data_sram_en), 32'(m_en));
        chk("sram_wen", 32'(data_sram_wen), 32'(m_wen));
        chk("sram_addr", data_sram_addr, {p_alu[31:2], 2'b00});
        chk("ms_alu_result", ms_alu_result, p_alu);
        chk("ms_rt_cont", ms_rt_cont, p_rt);
        chk("ms_mode", 32'(ms_mode), 32'(p_mode));
        chk("ms_gr_we", 32'(ms_gr_we), 32'(p_we));
        chk("ms_dest", 32'(ms_dest), 32'(p_dest));
        if (m_en && p_st != 3'd0) chk("sram_wdata", data_sram_wdata, m_wdata);
        if (wb_load) chk("ms_ld_rdata", ms_ld_rdata, wb_exp);
    endtask

    task automatic idle(input logic ws);
        step(1'b0, $urandom, $urandom, 6'd0, 3'd0, ws);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 32'(ms_to_ws_valid), 32'd0);
        chk({tag, "_en"}, 32'(data_sram_en), 32'd0);
        chk({tag, "_wen"}, 32'(data_sram_wen), 32'd0);
        chk({tag, "_alu"}, ms_alu_result, 32'd0);
        chk({tag, "_mode"}, 32'(ms_mode), 32'd0);
    endtask

    initial begin
        int nreq;
        logic        v;
        logic [2:0]  st;
        logic [5:0]  mode;
        int          kind;

        resetn = 1'b0; es_to_ms_valid = 1'b0; es_alu_result = '0; es_rt_cont = '0;
        es_mode = '0; es_st_op = '0; es_gr_we = 1'b0; es_dest = '0; ws_allowin = 1'b1;
        data_sram_rdata = '0; idle_zero = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        model_reset();
        model_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("rst");
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        resetn = 1'b1;

        // directed stores
        svec = '{
            '{3'd1, 32'h1001, 4'b0010, 32'h44444444},
            '{3'd4, 32'h1001, 4'b0011, 32'h00001122},
            '{3'd5, 32'h1001, 4'b1110, 32'h22334400},
            '{3'd2, 32'h1002, 4'b1100, 32'h33443344},
            '{3'd1, 32'h1000, 4'b0001, 32'h44444444},
            '{3'd4, 32'h1000, 4'b0001, 32'h00000011},
            '{3'd5, 32'h1000, 4'b1111, 32'h11223344},
            '{3'd2, 32'h1000, 4'b0011, 32'h33443344},
            '{3'd3, 32'h1000, 4'b1111, 32'h11223344}
        };
        foreach (svec[i]) begin
            step(1'b1, svec[i].alu, 32'h11223344, 6'd0, svec[i].st, 1'b1);
            idle(1'b1);
            chk("dir_st_en", 32'(data_sram_en), 32'd1);
            chk("dir_st_wen", 32'(data_sram_wen), 32'(svec[i].wen));
            chk("dir_st_wdata", data_sram_wdata, svec[i].wd);
            chk("dir_st_addr", data_sram_addr, 32'h1000);
        end

        // misaligned sw is suppressed but still flows on
        step(1'b1, 32'h1002, 32'h11223344, 6'd0, 3'd3, 1'b1);
        idle(1'b1);
        chk("mis_en", 32'(data_sram_en), 32'd0);
        chk("mis_err", 32'(ms_addr_err), 32'd1);
        chk("mis_valid", 32'(ms_to_ws_valid), 32'd1);

        // WB stall on a load, then load-data hold while SRAM drives zero
        idle_zero = 1'b1;
        mem[0] = 32'hDEADBEEF;
        step(1'b1, 32'h2000, $urandom, LW, 3'd0, 1'b1);
        nreq = 0;
        repeat (3) begin
            step(1'b1, 32'h3000, $urandom, 6'd0, 3'd0, 1'b0);
            chk("stall_en", 32'(data_sram_en), 32'd0);
            chk("stall_allowin", 32'(ms_allowin), 32'd0);
            nreq += int'(data_sram_en);
        end
        step(1'b1, 32'h3000, $urandom, 6'd0, 3'd0, 1'b1);
        chk("stall_release_en", 32'(data_sram_en), 32'd1);
        chk("stall_release_addr", data_sram_addr, 32'h2000);
        nreq += int'(data_sram_en);
        repeat (3) begin
            idle(1'b0);
            chk("hold_ld_rdata", ms_ld_rdata, 32'hDEADBEEF);
            nreq += int'(data_sram_en);
        end
        chk("stall_one_request", 32'(nreq), 32'd1);

        // back-to-back loads
        idle(1'b1);
        mem[1] = 32'hA1A2A3A4;
        mem[2] = 32'hB1B2B3B4;
        step(1'b1, 32'h4, $urandom, LW, 3'd0, 1'b1);
        step(1'b1, 32'h8, $urandom, LW, 3'd0, 1'b1);
        chk("b2b_en0", 32'(data_sram_en), 32'd1);
        chk("b2b_addr0", data_sram_addr, 32'h4);
        idle(1'b1);
        chk("b2b_en1", 32'(data_sram_en), 32'd1);
        chk("b2b_addr1", data_sram_addr, 32'h8);
        chk("b2b_ld0", ms_ld_rdata, 32'hA1A2A3A4);
        idle(1'b1);
        chk("b2b_ld1", ms_ld_rdata, 32'hB1B2B3B4);
        idle_zero = 1'b0;

        // reset while a load's read data is pending
        step(1'b1, 32'h0C, $urandom, LW, 3'd0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        #2;
        resetn = 1'b0;
        es_to_ms_valid = 1'b0;
        #1;
        reset_checks("midrst");
        model_reset();
        model_outputs();
        @(posedge clk);
        @(negedge clk);
        reset_checks("midrst_hold");
        resetn = 1'b1;
        repeat (2) begin
            idle(1'b1);
            chk("post_rst_ld_passthru", ms_ld_rdata, data_sram_rdata);
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 2);
            st   = 3'd0;
            mode = 6'd0;
            if (kind == 1) mode = {1'b1, 1'b0, 3'($urandom_range(0, 4)), 1'($urandom)};
            if (kind == 2) st = 3'($urandom_range(1, 5));
            step(v, $urandom & 32'h0000_F03F, $urandom, mode, st, ($urandom_range(0, 3) != 0));
        end
        repeat (3) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
